// File: rtl/hv_pkg.sv
// Purpose  : shared types and sizing helpers for hypervector readout (sequencer state, beat count).
// Latency  : n/a (package only).
// Backpress: n/a (package only).
package hv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      LOAD,
      SEND,
      CLEAR
   } readout_state_t;

   localparam int DIM_DEFAULT    = 1023;
   localparam int BEAT_W_DEFAULT = 512;

   // Beats per hypervector; DIM is the MSB index, so the width is DIM+1.
   function automatic int nbeat(input int dim, input int beat_w);
      return (dim + 1) / beat_w;
   endfunction

   // Beat index width, never narrower than one bit so a single-beat vector still has an index.
   function automatic int beat_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hv_readout_sched.sv
// Purpose  : after job_done, wait SETTLE cycles, snapshot the sign vector and stream it out in BEAT_W beats, then pulse counter_clr.
// Latency  : job_done in cycle 0 -> first dst_valid in cycle SETTLE+2; counter_clr the cycle after the last handshake.
// Backpress: beats are held stable while dst_ready is low; dst_valid is registered and never depends on dst_ready.
//
// Ports:
//   clk, rst (async, active-low)      clock and reset
//   job_done                          one-cycle pulse: counters hold their final result
//   sign_bit[DIM:0]                   sign vector from the counter bank
//   dst_valid/dst_ready/dst_data/dst_last  output beat stream, low bits first
//   counter_clr                       one-cycle clear to the counter bank after the transfer
//   busy                              sequencer not idle
//   drop_err                          sticky: job_done arrived while busy
module hv_readout_sched
   import hv_pkg::*;
#(
   parameter int DIM    = DIM_DEFAULT,
   parameter int BEAT_W = BEAT_W_DEFAULT,
   parameter int SETTLE = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              job_done,
   input  logic [DIM:0]      sign_bit,
   input  logic              dst_ready,
   output logic              dst_valid,
   output logic [BEAT_W-1:0] dst_data,
   output logic              dst_last,
   output logic              counter_clr,
   output logic              busy,
   output logic              drop_err
);

   localparam int               NBEAT       = nbeat(DIM, BEAT_W);
   localparam int               IDX_W       = beat_idx_w(NBEAT);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NBEAT - 1);
   // Only compared while in the settle state, which is skipped entirely when SETTLE is 0.
   localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);

   readout_state_t    state_q, state_d;
   logic [3:0]        settle_cnt_q, settle_cnt_d;
   logic [IDX_W-1:0]  beat_idx_q;
   logic [DIM:0]      snapshot_q;
   logic              dst_valid_q;
   logic [BEAT_W-1:0] dst_data_q;
   logic              dst_last_q;
   logic              drop_err_q;
   logic [BEAT_W-1:0] next_beat;
   logic              hs;

   assign hs = dst_valid_q & dst_ready;

   // ---------------- FSM state register ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         settle_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
      end
   end

   // ---------------- FSM next state ----------------
   // The module parameter SETTLE shadows the enum literal, so the state is named via the package.
   always_comb begin
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (job_done) begin
               settle_cnt_d = '0;
               state_d      = (SETTLE == 0) ? LOAD : hv_pkg::SETTLE;
            end
         end
         hv_pkg::SETTLE: begin
            settle_cnt_d = settle_cnt_q + 4'd1;
            if (settle_cnt_q == SETTLE_LAST) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            state_d = SEND;
         end
         SEND: begin
            if (hs && (beat_idx_q == LAST_IDX)) begin
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------- beat mux ----------------
   // Selects the beat after the current one from the frozen snapshot.
   always_comb begin
      next_beat = '0;
      for (int k = 0; k < NBEAT; k++) begin
         if (int'(beat_idx_q) + 1 == k) begin
            next_beat = snapshot_q[k*BEAT_W +: BEAT_W];
         end
      end
   end

   // ---------------- snapshot and output registers ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_idx_q  <= '0;
         snapshot_q  <= '0;
         dst_valid_q <= 1'b0;
         dst_data_q  <= '0;
         dst_last_q  <= 1'b0;
         drop_err_q  <= 1'b0;
      end else begin
         if (job_done && (state_q != IDLE)) begin
            drop_err_q <= 1'b1;
         end

         if (state_q == LOAD) begin
            // Freeze the vector so later sign_bit activity cannot leak into the stream.
            snapshot_q  <= sign_bit;
            beat_idx_q  <= '0;
            dst_data_q  <= sign_bit[BEAT_W-1:0];
            dst_valid_q <= 1'b1;
            dst_last_q  <= (NBEAT == 1);
         end else if ((state_q == SEND) && hs) begin
            if (beat_idx_q == LAST_IDX) begin
               dst_valid_q <= 1'b0;
               dst_last_q  <= 1'b0;
            end else begin
               beat_idx_q <= beat_idx_q + 1'b1;
               dst_data_q <= next_beat;
               dst_last_q <= ((beat_idx_q + 1'b1) == LAST_IDX);
            end
         end
      end
   end

   assign dst_valid   = dst_valid_q;
   assign dst_data    = dst_data_q;
   assign dst_last    = dst_last_q;
   assign counter_clr = (state_q == CLEAR);
   assign busy        = (state_q != IDLE);
   assign drop_err    = drop_err_q;

endmodule

// File: tb/tb_hv_readout_sched.sv
// Purpose  : self-checking bench for hv_readout_sched (default config plus SETTLE=0 and single-beat corners).
// Latency  : n/a.
// Backpress: dst_ready driven always-high, 3-cycle stalls, or random.
module tb_hv_readout_sched;

   localparam int SET = 2;
   localparam int NB  = 2;
   localparam int BW  = 512;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          job_done = 1'b0;
   logic          dst_ready = 1'b0;
   logic [1023:0] sign_bit = '0;

   logic          m_valid, m_last, m_clr, m_busy, m_drop;
   logic [BW-1:0] m_data;
   logic          s_valid, s_last, s_clr, s_busy, s_drop;
   logic [BW-1:0] s_data;
   logic          n_valid, n_last, n_clr, n_busy, n_drop;
   logic [BW-1:0] n_data;

   int checks   = 0;
   int failures = 0;
   bit drop_exp = 1'b0;

   always #5 clk = ~clk;

   hv_readout_sched #(.DIM(1023), .BEAT_W(512), .SETTLE(2)) u_main (
      .clk(clk), .rst(rst), .job_done(job_done), .sign_bit(sign_bit), .dst_ready(dst_ready),
      .dst_valid(m_valid), .dst_data(m_data), .dst_last(m_last),
      .counter_clr(m_clr), .busy(m_busy), .drop_err(m_drop)
   );

   hv_readout_sched #(.DIM(1023), .BEAT_W(512), .SETTLE(0)) u_s0 (
      .clk(clk), .rst(rst), .job_done(job_done), .sign_bit(sign_bit), .dst_ready(dst_ready),
      .dst_valid(s_valid), .dst_data(s_data), .dst_last(s_last),
      .counter_clr(s_clr), .busy(s_busy), .drop_err(s_drop)
   );

   hv_readout_sched #(.DIM(511), .BEAT_W(512), .SETTLE(2)) u_n1 (
      .clk(clk), .rst(rst), .job_done(job_done), .sign_bit(sign_bit[511:0]), .dst_ready(dst_ready),
      .dst_valid(n_valid), .dst_data(n_data), .dst_last(n_last),
      .counter_clr(n_clr), .busy(n_busy), .drop_err(n_drop)
   );

   task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rand_sign();
      for (int i = 0; i < 32; i++) begin
         sign_bit[i*32 +: 32] = $urandom();
      end
   endtask

   // One job on the default instance. Expectations come from the transfer rules:
   // vector sampled in cycle SET+1, beats low-first, valid from cycle SET+2 until the
   // last handshake, clear the cycle after it, idle the cycle after that.
   task automatic run_xfer(input string name, input int mode, input int chg_c,
                           input int dup_c, input int rst_c);
      logic [1023:0] snap = '0;
      int hs = 0;
      int end_c = -1;
      int waited = 0;
      bit exp_busy;
      bit exp_valid;
      for (int c = 0; c < 300; c++) begin
         job_done = (c == 0) || (c == dup_c);
         if (c == chg_c) sign_bit = '1;
         case (mode)
            0:       dst_ready = 1'b1;
            1:       dst_ready = m_valid && (waited >= 3);
            default: dst_ready = 1'($urandom_range(0, 1));
         endcase
         if (c == SET + 1) snap = sign_bit;

         if (c == rst_c) begin
            rst = 1'b0;
            #1;
            chk($sformatf("%s/rst_valid", name), m_valid, 1'b0);
            chk($sformatf("%s/rst_clr", name), m_clr, 1'b0);
            chk($sformatf("%s/rst_busy", name), m_busy, 1'b0);
            chk($sformatf("%s/rst_drop", name), m_drop, 1'b0);
            drop_exp  = 1'b0;
            job_done  = 1'b0;
            dst_ready = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("%s/post_rst_clr", name), m_clr, 1'b0);
            chk($sformatf("%s/post_rst_busy", name), m_busy, 1'b0);
            @(posedge clk); #1;
            return;
         end

         @(negedge clk);
         exp_busy  = (c >= 1) && ((end_c < 0) || (c <= end_c + 1));
         exp_valid = (c >= SET + 2) && (end_c < 0);
         chk($sformatf("%s/c%0d_busy", name, c), m_busy, exp_busy);
         chk($sformatf("%s/c%0d_valid", name, c), m_valid, exp_valid);
         chk($sformatf("%s/c%0d_clr", name, c), m_clr, (end_c >= 0) && (c == end_c + 1));
         chk($sformatf("%s/c%0d_drop", name, c), m_drop, drop_exp);
         if (exp_valid && m_valid) begin
            chk($sformatf("%s/beat%0d_data", name, hs), m_data, snap[hs*BW +: BW]);
            chk($sformatf("%s/beat%0d_last", name, hs), m_last, hs == NB - 1);
         end
         if (m_valid && dst_ready) begin
            hs++;
            waited = 0;
            if ((hs == NB) && (end_c < 0)) end_c = c;
         end else if (m_valid) begin
            waited++;
         end
         if (job_done && exp_busy) drop_exp = 1'b1;
         if ((end_c >= 0) && (c == end_c + 3)) begin
            job_done  = 1'b0;
            dst_ready = 1'b0;
            @(posedge clk); #1;
            return;
         end
         @(posedge clk); #1;
      end
      chk($sformatf("%s/timeout", name), end_c >= 0, 1'b1);
      job_done  = 1'b0;
      dst_ready = 1'b0;
   endtask

   initial begin
      logic [1023:0] cs;
      rst       = 1'b0;
      job_done  = 1'b0;
      dst_ready = 1'b0;
      #12;
      chk("reset_valid", m_valid, 1'b0);
      chk("reset_data", m_data, '0);
      chk("reset_last", m_last, 1'b0);
      chk("reset_clr", m_clr, 1'b0);
      chk("reset_busy", m_busy, 1'b0);
      chk("reset_drop", m_drop, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;

      // Corners: SETTLE=0 two-beat instance and single-beat instance, ready held high.
      rand_sign();
      cs = sign_bit;
      for (int c = 0; c < 9; c++) begin
         job_done  = (c == 0);
         dst_ready = 1'b1;
         @(negedge clk);
         chk($sformatf("s0/c%0d_valid", c), s_valid, (c == 2) || (c == 3));
         chk($sformatf("s0/c%0d_clr", c), s_clr, c == 4);
         chk($sformatf("s0/c%0d_busy", c), s_busy, (c >= 1) && (c <= 4));
         if (c == 2) begin
            chk("s0/beat0_data", s_data, cs[BW-1:0]);
            chk("s0/beat0_last", s_last, 1'b0);
         end
         if (c == 3) begin
            chk("s0/beat1_data", s_data, cs[2*BW-1:BW]);
            chk("s0/beat1_last", s_last, 1'b1);
         end
         chk($sformatf("n1/c%0d_valid", c), n_valid, c == 4);
         chk($sformatf("n1/c%0d_last", c), n_last, c == 4);
         chk($sformatf("n1/c%0d_clr", c), n_clr, c == 5);
         chk($sformatf("n1/c%0d_busy", c), n_busy, (c >= 1) && (c <= 5));
         if (c == 4) chk("n1/beat0_data", n_data, cs[BW-1:0]);
         @(posedge clk); #1;
      end
      job_done  = 1'b0;
      dst_ready = 1'b0;

      sign_bit = {128{8'hA5}};
      run_xfer("b2b_a5", 0, -1, -1, -1);
      rand_sign();
      run_xfer("b2b_rand", 0, -1, -1, -1);
      rand_sign();
      run_xfer("bp", 1, -1, -1, -1);
      rand_sign();
      run_xfer("iso", 1, 5, -1, -1);
      rand_sign();
      run_xfer("ovl", 0, -1, 4, -1);
      for (int i = 0; i < 4; i++) begin
         rand_sign();
         run_xfer($sformatf("rnd%0d", i), 2, -1, -1, -1);
      end
      rand_sign();
      run_xfer("rst", 0, -1, -1, 5);
      rand_sign();
      run_xfer("post_rst", 0, -1, -1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hv_readout_sched.md
Name: hv_readout_sched

Overview:
- Sequences readout of the per-dimension sign vector produced by the counter bank after a compute job.
- Waits for the counter sign pipeline to settle, then snapshots the full hypervector.
- Serialises the snapshot into BEAT_W-bit beats on a valid/ready output stream, flagging the last beat.
- Pulses a clear to the counter bank when the transfer ends.
- Sits between the counter/sign-bit bank and the DMA write channel, replacing ad-hoc stream_v/last_stream timing.

Parameters:
- DIM, 1023: hypervector MSB index; vector width is DIM+1.
- BEAT_W, 512: output beat width; DIM+1 must be an integer multiple of BEAT_W.
- SETTLE, 2: cycles from job-done to a valid sign vector, 0..15.
- NBEAT (localparam): (DIM+1)/BEAT_W.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous reset, active-low.
- job_done, in, 1: single-cycle pulse; all cores have stored their final result.
- sign_bit, in, DIM+1: sign vector from the counter bank.
- dst_ready, in, 1: downstream accepts a beat.
- dst_valid, out, 1: beat valid.
- dst_data, out, BEAT_W: beat payload.
- dst_last, out, 1: final beat of the vector.
- counter_clr, out, 1: one-cycle clear pulse to the counter bank.
- busy, out, 1: sequencer is not IDLE.
- drop_err, out, 1: sticky; set when job_done arrives while busy.

Behaviour:
- Reset (rst=0, async): state=IDLE, settle_cnt=0, beat_idx=0, snapshot=0.
- Reset values of outputs: dst_valid=0, dst_data=0, dst_last=0, counter_clr=0, busy=0, drop_err=0.
- Reset mid-transfer aborts immediately: dst_valid drops asynchronously and no counter_clr is issued.
- FSM states: IDLE, SETTLE, LOAD, SEND, CLEAR.
- IDLE: when job_done=1 at an edge, go to SETTLE with settle_cnt=0. If SETTLE==0, go straight to LOAD.
- SETTLE: settle_cnt increments each cycle. On the edge where settle_cnt==SETTLE-1, go to LOAD.
- LOAD: at the edge, snapshot<=sign_bit, beat_idx<=0, dst_data<=sign_bit[BEAT_W-1:0], dst_valid<=1; go to SEND.
- SEND, hold rule: dst_data, dst_last and dst_valid stay stable while dst_valid=1 and dst_ready=0.
- SEND, handshake (dst_valid and dst_ready at an edge), non-final beat: beat_idx++ and dst_data<=snapshot[(beat_idx+1)*BEAT_W +: BEAT_W].
- SEND, handshake on beat_idx==NBEAT-1: dst_valid<=0, go to CLEAR.
- Beat order is low bits first: beat k carries bits [k*BEAT_W +: BEAT_W].
- dst_last = dst_valid && beat_idx==NBEAT-1, registered alongside dst_data.
- dst_valid must not depend combinationally on dst_ready.
- CLEAR: counter_clr=1 for exactly one cycle, then IDLE.
- busy=1 in every state except IDLE.
- Latency with job_done in cycle 0: SETTLE cycles 1..SETTLE, LOAD in cycle SETTLE+1, first dst_valid in cycle SETTLE+2.
- Best case with dst_ready held high: valid for NBEAT consecutive cycles, then counter_clr in the next cycle, busy=0 the cycle after that.
- job_done while busy (including the CLEAR cycle): ignored and sets drop_err. Only reset clears drop_err.
- NBEAT==1: the first beat carries dst_last=1.
- Snapshot isolates the stream from sign_bit changes after LOAD.
- beat_idx width is $clog2(NBEAT), minimum 1. It never wraps: the transition to CLEAR precedes any wrap.

Decomposition:
- Shared package hv_pkg: typedef enum logic [2:0] readout_state_t {IDLE, SETTLE, LOAD, SEND, CLEAR}; localparams DIM_DEFAULT=1023, BEAT_W_DEFAULT=512.
- The NBEAT / beat-index-width helper function also lives in hv_pkg, so the core top and the DMA block agree on beat count.
- No sub-module: one FSM with a snapshot register and beat mux is a single cohesive block.

Test Plan (DIM=1023, BEAT_W=512, SETTLE=2 unless noted):
- Back-to-back readout: sign_bit=1024'h...A5 pattern, job_done in cycle 0, dst_ready=1 -> dst_valid in cycles 4-5. Beat 0 = bits[511:0] with last=0, beat 1 = bits[1023:512] with last=1; counter_clr=1 in cycle 6; busy=0 from cycle 7.
- Backpressure: dst_ready low for 3 cycles on each beat -> dst_data and dst_last held stable, exactly 2 handshakes, clr after the second.
- Snapshot isolation: sign_bit changed to all-ones in cycle 5 while beat 0 is stalled -> both beats carry the value sampled in LOAD (cycle 3).
- Overlap: second job_done in cycle 4 -> ignored, drop_err=1 and stays set, single transfer only.
- Reset mid-transfer: rst=0 during beat 1 -> dst_valid=0 immediately, no counter_clr. After release, a new job_done gives a full 2-beat transfer.
- Corners: SETTLE=0 -> dst_valid in cycle 2. DIM=511 (NBEAT=1) -> single beat with dst_last=1.
